branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-stage consumer of the branch history table's predictions.
- Compares the carried prediction (hit, taken, target, index) against the actual branch outcome.
- Drives the BHT training update back to the predictor.
- On a mispredict, issues a redirect PC and a multi-cycle front-end flush that squashes wrong-path instructions.

Parameters:
- IDX_W, 4, BHT index width carried down the pipeline
- ADDR_W, 32, PC/target width
- FLUSH_CYCLES, 2, cycles flush is held after a mispredict (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  instruction in execute stage is valid
- ex_opcode  in  6  opcode; branch when 4, 5, 6 or 7
- ex_pc  in  ADDR_W  PC of execute-stage instruction
- ex_index  in  IDX_W  BHT index carried from fetch
- ex_hit  in  1  BHT tag matched at fetch
- ex_pred_taken  in  1  predicted direction (valid only when ex_hit)
- ex_pred_target  in  ADDR_W  predicted target (valid only when ex_hit)
- ex_taken  in  1  actual branch outcome
- ex_target  in  ADDR_W  actual computed target
- upd_valid  out  1  one-cycle BHT update strobe
- upd_index  out  IDX_W  index to update
- upd_taken  out  1  actual outcome for training
- upd_target  out  ADDR_W  actual target for training
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  ADDR_W  corrected fetch PC
- flush  out  1  squash fetch/decode; held FLUSH_CYCLES cycles

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; flush counter 0. Reset mid-flush aborts the flush immediately, with no residual redirect.
- Branch qualifier: is_br = ex_valid && (ex_opcode in 4..7) && state==IDLE.
- Mispredict:
  - If ex_hit: mis = (ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target).
  - If !ex_hit: the prediction is not-taken, so mis = ex_taken.
- Latency: all outputs are registered and appear on the cycle after the qualifying execute cycle.
- Update: each is_br produces exactly one upd_valid pulse, hit or miss, with upd_index=ex_index, upd_taken=ex_taken, upd_target=ex_target.
- Redirect:
  - On mis, redirect_valid pulses for one cycle.
  - redirect_pc = ex_taken ? ex_target : ex_pc+4, with the add mod 2^ADDR_W (wrap, no carry out).
- FSM states:
  - IDLE: on is_br && mis -> FLUSH, load cnt=FLUSH_CYCLES, assert flush; otherwise stay.
  - FLUSH: flush=1; cnt decrements each cycle; at cnt==1 return to IDLE with flush deasserting the next cycle. flush is high for exactly FLUSH_CYCLES cycles total.
- While in FLUSH:
  - ex_valid inputs are wrong-path and are ignored: no upd_valid, no redirect, no re-trigger.
  - A branch arriving on the cycle the FSM returns to IDLE is processed normally.
- Non-branch ex_valid: no outputs and no state change.
- Correctly predicted branch: upd_valid only; no flush, no redirect.
- Back-to-back correct branches: one upd_valid per cycle, with no bubbles required.

Optional Feature:
- Macro BRANCH_RESOLVE_STATS_EN.
- When defined, adds three outputs:
  - stat_branches (16): saturating count of is_br.
  - stat_mispredicts (16): saturating count of is_br && mis.
  - stat_tgt_miss (16): saturating count of mispredicts where the direction was right but the target was wrong.
- All three reset to 0 and hold at 16'hFFFF.
- When undefined, these ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset, then opcode=4, ex_hit=1, pred_taken=1, taken=1, targets both 0x100, index 3 -> next cycle upd_valid=1, upd_index=3, upd_taken=1; redirect_valid=0, flush=0.
- opcode=5, ex_hit=1, pred_taken=1, taken=0, pc=0x40 -> redirect_valid pulse with redirect_pc=0x44; flush high exactly 2 cycles; a branch issued during flush gives no upd_valid.
- opcode=6, ex_hit=0, taken=1, target=0x200 -> upd_valid=1, redirect_pc=0x200, flush 2 cycles; a same-case branch with taken=0 gives upd_valid only.
- Direction correct but target wrong: pred_target=0x300, ex_target=0x304, taken=1 -> mispredict, redirect_pc=0x304; stat_tgt_miss increments when the stats macro is defined.
- Assert rst on the 1st flush cycle -> flush=0 and redirect_valid=0 on the next cycle; FSM in IDLE; a following correct branch updates normally.
- pc=0xFFFFFFFC, not-taken mispredict -> redirect_pc=0x00000000. With FLUSH_CYCLES=1, flush lasts 1 cycle. Non-branch opcode 0 -> no outputs.

Source files
------------

// File: rtl/branch_resolve_if.sv
// branch_resolve_if
//   Bundle between the execute stage and the branch resolver.
//   master: execute stage side (drives ex_*, receives training/redirect/flush)
//   slave : branch_resolve side (receives ex_*, drives upd_*, redirect_*, flush)
//
//   ex_valid, ex_opcode, ex_pc, ex_index, ex_hit, ex_pred_taken,
//   ex_pred_target, ex_taken, ex_target          execute-stage branch info
//   upd_valid, upd_index, upd_taken, upd_target  BHT training update
//   redirect_valid, redirect_pc                  fetch redirect pulse
//   flush                                        front-end squash
interface branch_resolve_if #(
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 32
);
    logic              ex_valid;
    logic [5:0]        ex_opcode;
    logic [ADDR_W-1:0] ex_pc;
    logic [IDX_W-1:0]  ex_index;
    logic              ex_hit;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;

    logic              upd_valid;
    logic [IDX_W-1:0]  upd_index;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;

    modport master (
        output ex_valid, ex_opcode, ex_pc, ex_index, ex_hit,
               ex_pred_taken, ex_pred_target, ex_taken, ex_target,
        input  upd_valid, upd_index, upd_taken, upd_target,
               redirect_valid, redirect_pc, flush
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_pc, ex_index, ex_hit,
               ex_pred_taken, ex_pred_target, ex_taken, ex_target,
        output upd_valid, upd_index, upd_taken, upd_target,
               redirect_valid, redirect_pc, flush
    );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve
//   Execute-stage resolution of BHT predictions. Compares the prediction
//   carried down from fetch with the actual outcome, emits one BHT training
//   update per resolved branch, and on a mispredict emits a one-cycle
//   redirect plus a FLUSH_CYCLES-long front-end flush. Branches seen while
//   flushing are wrong-path and ignored. All outputs are registered.
//
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     bus        branch_resolve_if.slave (ex_* in; upd_*, redirect_*, flush out)
//     stat_*     optional 16-bit saturating counters (branches, mispredicts,
//                target-only mispredicts), present only when the macro
//                BRANCH_RESOLVE_STATS_EN is defined
module branch_resolve #(
    parameter int IDX_W        = 4,
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef BRANCH_RESOLVE_STATS_EN
    output logic [15:0]             stat_branches,
    output logic [15:0]             stat_mispredicts,
    output logic [15:0]             stat_tgt_miss,
`endif
    branch_resolve_if.slave         bus
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic              is_branch_p0;
    logic              br_p0;
    logic              dir_miss_p0;
    logic              tgt_miss_p0;
    logic              mis_p0;
    logic [ADDR_W-1:0] redir_pc_p0;

    // ---- execute-stage resolution (p0) ----
    // Opcodes 4..7 share the pattern 0001xx.
    assign is_branch_p0 = (bus.ex_opcode[5:2] == 4'b0001);
    assign br_p0        = bus.ex_valid && is_branch_p0 && (state_q == IDLE);

    // A BHT miss is treated as a not-taken prediction, so only a taken
    // branch can mispredict; its target is never compared.
    assign dir_miss_p0  = bus.ex_hit ? (bus.ex_pred_taken != bus.ex_taken) : bus.ex_taken;
    assign tgt_miss_p0  = bus.ex_hit && bus.ex_pred_taken && bus.ex_taken &&
                          (bus.ex_pred_target != bus.ex_target);
    assign mis_p0       = dir_miss_p0 || tgt_miss_p0;

    // Fall-through wraps modulo 2^ADDR_W.
    assign redir_pc_p0  = bus.ex_taken ? bus.ex_target : (bus.ex_pc + ADDR_W'(4));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (br_p0 && mis_p0) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ---- registered outputs (p1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            cnt_q              <= 4'd0;
            bus.upd_valid      <= 1'b0;
            bus.upd_index      <= '0;
            bus.upd_taken      <= 1'b0;
            bus.upd_target     <= '0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.flush          <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            bus.upd_valid      <= br_p0;
            bus.redirect_valid <= br_p0 && mis_p0;
            // flush mirrors the registered FSM state so it is high for
            // exactly the cycles spent in FLUSH.
            bus.flush          <= (state_d == FLUSH);
            if (br_p0) begin
                bus.upd_index  <= bus.ex_index;
                bus.upd_taken  <= bus.ex_taken;
                bus.upd_target <= bus.ex_target;
            end
            if (br_p0 && mis_p0) begin
                bus.redirect_pc <= redir_pc_p0;
            end
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= 16'd0;
            stat_mispredicts <= 16'd0;
            stat_tgt_miss    <= 16'd0;
        end else if (br_p0) begin
            stat_branches <= sat_inc(stat_branches);
            if (mis_p0) begin
                stat_mispredicts <= sat_inc(stat_mispredicts);
            end
            // Direction correct, target wrong.
            if (tgt_miss_p0) begin
                stat_tgt_miss <= sat_inc(stat_tgt_miss);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

    localparam int IDX_W  = 4;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus driving two instances (FLUSH_CYCLES = 2 and 1)
    logic              s_valid = 1'b0;
    logic [5:0]        s_opcode = '0;
    logic [ADDR_W-1:0] s_pc = '0;
    logic [IDX_W-1:0]  s_index = '0;
    logic              s_hit = 1'b0;
    logic              s_pt = 1'b0;
    logic [ADDR_W-1:0] s_ptgt = '0;
    logic              s_taken = 1'b0;
    logic [ADDR_W-1:0] s_tgt = '0;

    branch_resolve_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus0 ();
    branch_resolve_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus1 ();

    assign bus0.ex_valid = s_valid;        assign bus1.ex_valid = s_valid;
    assign bus0.ex_opcode = s_opcode;      assign bus1.ex_opcode = s_opcode;
    assign bus0.ex_pc = s_pc;              assign bus1.ex_pc = s_pc;
    assign bus0.ex_index = s_index;        assign bus1.ex_index = s_index;
    assign bus0.ex_hit = s_hit;            assign bus1.ex_hit = s_hit;
    assign bus0.ex_pred_taken = s_pt;      assign bus1.ex_pred_taken = s_pt;
    assign bus0.ex_pred_target = s_ptgt;   assign bus1.ex_pred_target = s_ptgt;
    assign bus0.ex_taken = s_taken;        assign bus1.ex_taken = s_taken;
    assign bus0.ex_target = s_tgt;         assign bus1.ex_target = s_tgt;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [15:0] st_br0, st_mis0, st_tm0, st_br1, st_mis1, st_tm1;
`endif

    branch_resolve #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .FLUSH_CYCLES(2)) u0 (
        .clk(clk),
        .rst(rst),
`ifdef BRANCH_RESOLVE_STATS_EN
        .stat_branches(st_br0),
        .stat_mispredicts(st_mis0),
        .stat_tgt_miss(st_tm0),
`endif
        .bus(bus0)
    );

    branch_resolve #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .FLUSH_CYCLES(1)) u1 (
        .clk(clk),
        .rst(rst),
`ifdef BRANCH_RESOLVE_STATS_EN
        .stat_branches(st_br1),
        .stat_mispredicts(st_mis1),
        .stat_tgt_miss(st_tm1),
`endif
        .bus(bus1)
    );

    // Observed outputs as arrays indexed by instance
    logic              o_uv [2];
    logic [IDX_W-1:0]  o_ui [2];
    logic              o_ut [2];
    logic [ADDR_W-1:0] o_utg[2];
    logic              o_rv [2];
    logic [ADDR_W-1:0] o_rpc[2];
    logic              o_fl [2];
    assign o_uv[0] = bus0.upd_valid;       assign o_uv[1] = bus1.upd_valid;
    assign o_ui[0] = bus0.upd_index;       assign o_ui[1] = bus1.upd_index;
    assign o_ut[0] = bus0.upd_taken;       assign o_ut[1] = bus1.upd_taken;
    assign o_utg[0] = bus0.upd_target;     assign o_utg[1] = bus1.upd_target;
    assign o_rv[0] = bus0.redirect_valid;  assign o_rv[1] = bus1.redirect_valid;
    assign o_rpc[0] = bus0.redirect_pc;    assign o_rpc[1] = bus1.redirect_pc;
    assign o_fl[0] = bus0.flush;           assign o_fl[1] = bus1.flush;

    // Reference model: each instance tracks how many flush cycles remain.
    int                fcs [2] = '{2, 1};
    int                rem [2];
    bit                e_uv[2], e_ut[2], e_rv[2], e_fl[2];
    logic [IDX_W-1:0]  e_ui[2];
    logic [ADDR_W-1:0] e_utg[2], e_rpc[2];
    int                m_br[2], m_mis[2], m_tm[2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r);
        rst = r;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                rem[k] = 0;
                e_uv[k] = 0; e_ut[k] = 0; e_rv[k] = 0; e_fl[k] = 0;
                e_ui[k] = '0; e_utg[k] = '0; e_rpc[k] = '0;
                m_br[k] = 0; m_mis[k] = 0; m_tm[k] = 0;
            end else begin
                bit is_br, pred_tk, mis, tmiss;
                is_br   = s_valid && (s_opcode >= 6'd4) && (s_opcode <= 6'd7) && (rem[k] == 0);
                pred_tk = s_hit ? s_pt : 1'b0;
                mis     = (pred_tk != s_taken) || (s_taken && s_hit && (s_ptgt != s_tgt));
                tmiss   = mis && (pred_tk == s_taken);
                e_uv[k] = is_br;
                e_rv[k] = is_br && mis;
                if (is_br) begin
                    e_ui[k]  = s_index;
                    e_ut[k]  = s_taken;
                    e_utg[k] = s_tgt;
                    m_br[k]  = (m_br[k] < 65535) ? m_br[k] + 1 : 65535;
                    if (mis) m_mis[k] = (m_mis[k] < 65535) ? m_mis[k] + 1 : 65535;
                    if (tmiss) m_tm[k] = (m_tm[k] < 65535) ? m_tm[k] + 1 : 65535;
                end
                if (is_br && mis) begin
                    e_rpc[k] = s_taken ? s_tgt : s_pc + 32'd4;
                    rem[k]   = fcs[k];
                end else if (rem[k] > 0) begin
                    rem[k]--;
                end
                e_fl[k] = (rem[k] > 0);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d.upd_valid", k), 64'(o_uv[k]), 64'(e_uv[k]));
            check($sformatf("u%0d.redirect_valid", k), 64'(o_rv[k]), 64'(e_rv[k]));
            check($sformatf("u%0d.flush", k), 64'(o_fl[k]), 64'(e_fl[k]));
            if (e_uv[k]) begin
                check($sformatf("u%0d.upd_index", k), 64'(o_ui[k]), 64'(e_ui[k]));
                check($sformatf("u%0d.upd_taken", k), 64'(o_ut[k]), 64'(e_ut[k]));
                check($sformatf("u%0d.upd_target", k), 64'(o_utg[k]), 64'(e_utg[k]));
            end
            if (e_rv[k]) begin
                check($sformatf("u%0d.redirect_pc", k), 64'(o_rpc[k]), 64'(e_rpc[k]));
            end
        end
`ifdef BRANCH_RESOLVE_STATS_EN
        check("u0.stat_branches", 64'(st_br0), 64'(m_br[0]));
        check("u0.stat_mispredicts", 64'(st_mis0), 64'(m_mis[0]));
        check("u0.stat_tgt_miss", 64'(st_tm0), 64'(m_tm[0]));
        check("u1.stat_branches", 64'(st_br1), 64'(m_br[1]));
        check("u1.stat_mispredicts", 64'(st_mis1), 64'(m_mis[1]));
        check("u1.stat_tgt_miss", 64'(st_tm1), 64'(m_tm[1]));
`endif
    endtask

    task automatic br(input logic [5:0] op, input logic [31:0] pc, input logic [3:0] idx,
                      input bit hit, input bit pt, input logic [31:0] ptgt,
                      input bit tk, input logic [31:0] tgt);
        s_valid = 1'b1; s_opcode = op; s_pc = pc; s_index = idx;
        s_hit = hit; s_pt = pt; s_ptgt = ptgt; s_taken = tk; s_tgt = tgt;
        step(1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b0;
            step(1'b0);
        end
    endtask

    initial begin
        step(1'b1);
        step(1'b1);
        idle(1);

        // Correct taken branch
        br(6'd4, 32'h1000, 4'd3, 1, 1, 32'h100, 1, 32'h100);
        // Direction mispredict (predicted taken, actually not taken), then
        // wrong-path branches during flush, then one on the return-to-idle cycle
        br(6'd5, 32'h40, 4'd5, 1, 1, 32'h80, 0, 32'h80);
        br(6'd4, 32'h44, 4'd6, 1, 1, 32'h90, 1, 32'h90);
        br(6'd4, 32'h48, 4'd7, 1, 1, 32'h90, 1, 32'h90);
        br(6'd7, 32'h4C, 4'd8, 1, 0, 32'h0, 0, 32'h0);
        idle(2);
        // BHT miss, actually taken -> mispredict to target
        br(6'd6, 32'h180, 4'd9, 0, 0, 32'h0, 1, 32'h200);
        idle(3);
        // BHT miss, not taken -> update only
        br(6'd6, 32'h180, 4'd9, 0, 0, 32'h0, 0, 32'h200);
        idle(1);
        // Direction right, target wrong
        br(6'd4, 32'h500, 4'd2, 1, 1, 32'h300, 1, 32'h304);
        idle(3);
        // Reset on first flush cycle, then a correct branch
        br(6'd5, 32'h600, 4'd1, 1, 0, 32'h0, 1, 32'h700);
        s_valid = 1'b0;
        step(1'b1);
        br(6'd4, 32'h800, 4'd4, 1, 1, 32'h900, 1, 32'h900);
        idle(1);
        // PC wrap on not-taken mispredict
        br(6'd7, 32'hFFFF_FFFC, 4'd1, 1, 1, 32'h10, 0, 32'h10);
        idle(3);
        // Non-branch valid instruction
        br(6'd0, 32'h1234, 4'd5, 1, 0, 32'h0, 1, 32'h5000);
        br(6'd8, 32'h1238, 4'd5, 0, 0, 32'h0, 1, 32'h5000);
        // Back-to-back correct branches
        for (int i = 0; i < 4; i++)
            br(6'(4 + i), 32'h2000 + 32'(i * 4), 4'(i), 1, 0, 32'h0, 0, 32'h3000);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            s_valid  = ($urandom_range(0, 9) < 8);
            s_opcode = 6'($urandom_range(0, 9));
            s_pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            s_index  = 4'($urandom);
            s_hit    = 1'($urandom);
            s_pt     = 1'($urandom);
            s_taken  = 1'($urandom);
            s_tgt    = 32'($urandom_range(0, 3)) << 4;
            s_ptgt   = ($urandom_range(0, 3) == 0) ? (32'($urandom_range(0, 3)) << 4) : s_tgt;
            step($urandom_range(0, 63) == 0);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
